pepper_scheduler: RTL and testbench
===================================

Name: pepper_scheduler

Overview:
Sequences the chef's pepper weapon as a timed resource: edge-detects the throw key, arbitrates throws against the remaining-pepper inventory and a cooldown, and runs a multi-frame spray window that tests two enemies (sausage, egg) against a directional hit box. Each enemy gets an independent stun timer, and inventory is refilled by bonus pickups. Sits between keyboard/chef-position logic and the enemy movement FSMs, which freeze while their hit output is high.

Parameters:
MAX_PEPPER, 5, inventory saturation ceiling (1..7)
START_PEPPER, 3, inventory loaded at reset (<= MAX_PEPPER)
SPRAY_FRAMES, 8, frames the spray hit box stays active per throw (>=1)
COOLDOWN_FRAMES, 30, frames after spray before next throw is accepted (>=1)
STUN_FRAMES, 600, frames an enemy stays stunned after being hit (1..1023)
HIT_DX, 24, horizontal reach of spray in pixels
HIT_DY, 4, vertical half-height of spray in pixels
THROW_KEY, 8'd19, keycode that throws pepper

Ports:
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  clock, one edge per video frame
keycode  in  8  current keyboard code
ChefX, ChefY  in  10 each  chef centre position
chef_dir  in  1  chef facing: 0 = left, 1 = right
EnemyX, EnemyY  in  10 each  sausage position
Enemy1X, Enemy1Y  in  10 each  egg position
bonus_pickup  in  1  one-frame pulse: add one pepper
pepper_count  out  3  remaining inventory
have_pepper  out  1  pepper_count != 0
spraying  out  1  high while in SPRAY
spray_dir  out  1  direction latched at throw (drives spray sprite)
sausage_hit  out  1  sausage stun timer != 0
egg_hit  out  1  egg stun timer != 0

Behaviour:
- Reset (async, any state): FSM=IDLE, pepper_count=START_PEPPER, phase counter=0, both stun timers=0, key history=0, spray_dir=0. Outputs: spraying=0, sausage_hit=0, egg_hit=0, have_pepper=(START_PEPPER!=0).
- Key edge: key_prev registers (keycode==THROW_KEY). A press is (keycode==THROW_KEY) && !key_prev. A held key throws once.
- FSM states: IDLE, SPRAY, COOLDOWN.
- IDLE: press && pepper_count!=0 -> SPRAY at the same edge; pepper_count decrements, spray_dir<=chef_dir, phase=0. Press with count 0 is ignored and does not set anything.
- SPRAY: hit test runs every cycle in SPRAY, including the first. Phase increments each cycle. When phase==SPRAY_FRAMES-1 -> COOLDOWN, phase=0. spraying=1 for exactly SPRAY_FRAMES cycles.
- COOLDOWN: presses are ignored. After COOLDOWN_FRAMES cycles -> IDLE. A press must occur after the return to IDLE (key still held does not count).
- Hit box: evaluate with 11-bit zero-extended compares and no subtraction, so there is no wrap near 0 or 639.
  - Y match: EnemyY+HIT_DY >= ChefY && EnemyY <= ChefY+HIT_DY.
  - spray_dir=1: EnemyX >= ChefX && EnemyX <= ChefX+HIT_DX.
  - spray_dir=0: EnemyX+HIT_DX >= ChefX && EnemyX <= ChefX.
- Stun: a hit loads that enemy's timer with STUN_FRAMES. A hit on an already stunned enemy reloads it. Otherwise a nonzero timer decrements by 1 per cycle and stops at 0. The hit output goes high the cycle after the first hitting edge and stays high exactly STUN_FRAMES cycles after the last hit.
- Inventory: bonus_pickup increments, saturating at MAX_PEPPER. Bonus and accepted throw on the same edge give a net change of 0. When at MAX, bonus plus throw gives MAX-1.
- The two enemy timers are fully independent. Both may be hit by one throw.

Optional Feature:
PEPPER_OMNI_EN: when defined, the X test ignores spray_dir and accepts EnemyX+HIT_DX >= ChefX && EnemyX <= ChefX+HIT_DX (both sides). spray_dir is still latched and output. When undefined, the directional box applies as above.

Test Plan:
- Reset, then observe: pepper_count=3, have_pepper=1, spraying=0, both hits 0. Assert Reset mid-SPRAY -> state returns to IDLE immediately and count reloads to 3.
- Chef (100,200) dir=1, sausage (120,202), keycode=19 for 1 cycle -> spraying high 8 cycles, count=2, sausage_hit high 600 cycles, egg_hit stays 0.
- Same positions, chef dir=0 -> no hit. With PEPPER_OMNI_EN defined -> sausage_hit asserted.
- Hold keycode=19 for 100 cycles starting with count=3 -> exactly one throw (count=2); release and press during COOLDOWN -> ignored; press after COOLDOWN -> count=1.
- ChefX=5 dir=0, egg at X=0, Y equal -> egg_hit=1 (no wrap). Egg at X=630 -> no hit.
- Count=5 plus bonus -> stays 5. Bonus and throw on the same edge with count 5 -> 4. Count 0, press -> no spray.

Source files
------------

// File: rtl/pepper_scheduler.sv
// pepper_scheduler: throw arbitration, spray window and enemy stun timers.
// Optional build macro PEPPER_OMNI_EN makes the spray box cover both sides.
module pepper_scheduler #(
  parameter int         MAX_PEPPER      = 5,
  parameter int         START_PEPPER    = 3,
  parameter int         SPRAY_FRAMES    = 8,
  parameter int         COOLDOWN_FRAMES = 30,
  parameter int         STUN_FRAMES     = 600,
  parameter int         HIT_DX          = 24,
  parameter int         HIT_DY          = 4,
  parameter logic [7:0] THROW_KEY       = 8'd19
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] ChefX,
  input  logic [9:0] ChefY,
  input  logic       chef_dir,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic [9:0] Enemy1X,
  input  logic [9:0] Enemy1Y,
  input  logic       bonus_pickup,
  output logic [2:0] pepper_count,
  output logic       have_pepper,
  output logic       spraying,
  output logic       spray_dir,
  output logic       sausage_hit,
  output logic       egg_hit
);

  typedef enum logic [1:0] {
    IDLE,
    SPRAY,
    COOLDOWN
  } state_t;

  localparam int PW = 16;

  state_t      state_q;
  logic [PW-1:0] phase_q;
  logic [2:0]  cnt_q, cnt_b, cnt_d;
  logic [9:0]  stun_s_q, stun_s_d;
  logic [9:0]  stun_e_q, stun_e_d;
  logic        key_prev_q;
  logic        dir_q;
  logic        spray_q;
  logic        key_now;
  logic        press;
  logic        throw_ok;
  logic        hit_s;
  logic        hit_e;

  // Widened compares: no subtraction, so no wrap near the screen edges.
  function automatic logic in_box(
    input logic       dir,
    input logic [9:0] cx,
    input logic [9:0] cy,
    input logic [9:0] ex,
    input logic [9:0] ey
  );
    logic [10:0] cxw, cyw, exw, eyw;
    logic        yok, xok;
    cxw = {1'b0, cx};
    cyw = {1'b0, cy};
    exw = {1'b0, ex};
    eyw = {1'b0, ey};
    yok = (eyw + 11'(HIT_DY) >= cyw)
       && (eyw <= cyw + 11'(HIT_DY));
`ifdef PEPPER_OMNI_EN
    xok = (exw + 11'(HIT_DX) >= cxw)
       && (exw <= cxw + 11'(HIT_DX))
       && (dir || !dir);
`else
    if (dir)
      xok = (exw >= cxw)
         && (exw <= cxw + 11'(HIT_DX));
    else
      xok = (exw + 11'(HIT_DX) >= cxw)
         && (exw <= cxw);
`endif
    return yok && xok;
  endfunction

  // Press detect, throw grant, inventory and stun next-state.
  always_comb begin
    key_now  = (keycode == THROW_KEY);
    press    = key_now && !key_prev_q;
    throw_ok = (state_q == IDLE) && press
            && (cnt_q != 3'd0);
    cnt_b = cnt_q;
    if (bonus_pickup && cnt_q != 3'(MAX_PEPPER))
      cnt_b = cnt_q + 3'd1;
    cnt_d = throw_ok ? cnt_b - 3'd1 : cnt_b;
    hit_s = (state_q == SPRAY)
         && in_box(dir_q, ChefX, ChefY,
                   EnemyX, EnemyY);
    hit_e = (state_q == SPRAY)
         && in_box(dir_q, ChefX, ChefY,
                   Enemy1X, Enemy1Y);
    stun_s_d = stun_s_q;
    if (hit_s)
      stun_s_d = 10'(STUN_FRAMES);
    else if (stun_s_q != 10'd0)
      stun_s_d = stun_s_q - 10'd1;
    stun_e_d = stun_e_q;
    if (hit_e)
      stun_e_d = 10'(STUN_FRAMES);
    else if (stun_e_q != 10'd0)
      stun_e_d = stun_e_q - 10'd1;
  end

  // Throw FSM: IDLE -> SPRAY -> COOLDOWN -> IDLE.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      dir_q   <= 1'b0;
      spray_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (throw_ok) begin
            state_q <= SPRAY;
            phase_q <= '0;
            dir_q   <= chef_dir;
            spray_q <= 1'b1;
          end
        end
        SPRAY: begin
          if (phase_q == PW'(SPRAY_FRAMES - 1)) begin
            state_q <= COOLDOWN;
            phase_q <= '0;
            spray_q <= 1'b0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        COOLDOWN: begin
          if (phase_q == PW'(COOLDOWN_FRAMES - 1)) begin
            state_q <= IDLE;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= '0;
          spray_q <= 1'b0;
        end
      endcase
    end
  end

  // Inventory, key history and per-enemy stun timers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cnt_q      <= 3'(START_PEPPER);
      key_prev_q <= 1'b0;
      stun_s_q   <= '0;
      stun_e_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      key_prev_q <= key_now;
      stun_s_q   <= stun_s_d;
      stun_e_q   <= stun_e_d;
    end
  end

  assign pepper_count = cnt_q;
  assign have_pepper  = (cnt_q != 3'd0);
  assign spraying     = spray_q;
  assign spray_dir    = dir_q;
  assign sausage_hit  = (stun_s_q != 10'd0);
  assign egg_hit      = (stun_e_q != 10'd0);

endmodule

// File: tb/tb_pepper_scheduler.sv
// tb_pepper_scheduler: vector table, hand sequences and random run
// checked against an edge-indexed reference model.
module tb_pepper_scheduler;

  localparam int MAXP  = 5;
  localparam int STARTP = 3;
  localparam int SPR   = 8;
  localparam int CD    = 30;
  localparam int STUN  = 600;
  localparam int DX    = 24;
  localparam int DY    = 4;
`ifdef PEPPER_OMNI_EN
  localparam bit OMNI = 1'b1;
`else
  localparam bit OMNI = 1'b0;
`endif

  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] ChefX, ChefY;
  logic       chef_dir;
  logic [9:0] EnemyX, EnemyY;
  logic [9:0] Enemy1X, Enemy1Y;
  logic       bonus_pickup;
  logic [2:0] pepper_count;
  logic       have_pepper;
  logic       spraying;
  logic       spray_dir;
  logic       sausage_hit;
  logic       egg_hit;

  pepper_scheduler dut (
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .ChefX        (ChefX),
    .ChefY        (ChefY),
    .chef_dir     (chef_dir),
    .EnemyX       (EnemyX),
    .EnemyY       (EnemyY),
    .Enemy1X      (Enemy1X),
    .Enemy1Y      (Enemy1Y),
    .bonus_pickup (bonus_pickup),
    .pepper_count (pepper_count),
    .have_pepper  (have_pepper),
    .spraying     (spraying),
    .spray_dir    (spray_dir),
    .sausage_hit  (sausage_hit),
    .egg_hit      (egg_hit)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: events are remembered by edge index.
  int n = 0;
  int last_throw;
  int last_hit_s;
  int last_hit_e;
  int m_count;
  bit m_kprev;
  bit m_dir;

  function automatic bit box(bit dir, int cx, int cy,
                             int ex, int ey);
    bit yok, xok;
    yok = (ey + DY >= cy) && (ey <= cy + DY);
    if (OMNI)
      xok = (ex + DX >= cx) && (ex <= cx + DX);
    else if (dir)
      xok = (ex >= cx) && (ex <= cx + DX);
    else
      xok = (ex + DX >= cx) && (ex <= cx);
    return yok && xok;
  endfunction

  task automatic model_reset();
    last_throw = -100000;
    last_hit_s = -1000000;
    last_hit_e = -1000000;
    m_count    = STARTP;
    m_kprev    = 1'b0;
    m_dir      = 1'b0;
  endtask

  task automatic model_edge();
    bit press, thr;
    int c;
    n++;
    press = (keycode == 8'd19) && !m_kprev;
    if (n >= last_throw + 1 && n <= last_throw + SPR) begin
      if (box(m_dir, int'(ChefX), int'(ChefY),
              int'(EnemyX), int'(EnemyY)))
        last_hit_s = n;
      if (box(m_dir, int'(ChefX), int'(ChefY),
              int'(Enemy1X), int'(Enemy1Y)))
        last_hit_e = n;
    end
    thr = press && (m_count != 0)
       && (n >= last_throw + SPR + CD + 1);
    c = m_count + (bonus_pickup ? 1 : 0);
    if (c > MAXP) c = MAXP;
    if (thr) begin
      c--;
      last_throw = n;
      m_dir = chef_dir;
    end
    m_count = c;
    m_kprev = (keycode == 8'd19);
  endtask

  function automatic logic [7:0] model_out();
    logic [7:0] r;
    r[7:5] = 3'(m_count);
    r[4]   = (m_count != 0);
    r[3]   = (n >= last_throw) && (n <= last_throw + SPR - 1);
    r[2]   = m_dir;
    r[1]   = (n - last_hit_s) < STUN;
    r[0]   = (n - last_hit_e) < STUN;
    return r;
  endfunction

  task automatic chk(string name, logic [7:0] act,
                     logic [7:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s @%0t: got %h want %h",
               name, $time, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic check_all(string name);
    chk(name, {pepper_count, have_pepper, spraying,
               spray_dir, sausage_hit, egg_hit},
        model_out());
  endtask

  task automatic step();
    model_edge();
    @(posedge frame_clk);
    #1;
    check_all("model");
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    model_reset();
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    check_all("post_reset");
  endtask

  function automatic logic [9:0] clampv(int v, int hi);
    if (v < 0) return 10'd0;
    if (v > hi) return 10'(hi);
    return 10'(v);
  endfunction

  typedef struct {
    int         ncyc;
    logic [7:0] key;
    bit         bonus;
    bit         dir;
    int         cx;
    int         ex;
    int         ey;
    int         e1x;
    logic [2:0] cnt;
    bit         spr;
    bit         sh;
    bit         eh;
  } vec_t;

  vec_t vt[19];

  initial begin
    vt[0]  = '{1,   8'd19, 0, 1, 100, 120, 202, 500, 3'd2, 1, 0, 0};
    vt[1]  = '{1,   8'd0,  0, 1, 100, 120, 202, 500, 3'd2, 1, 1, 0};
    vt[2]  = '{6,   8'd0,  0, 1, 100, 120, 202, 500, 3'd2, 1, 1, 0};
    vt[3]  = '{1,   8'd0,  0, 1, 100, 120, 202, 500, 3'd2, 0, 1, 0};
    vt[4]  = '{598, 8'd0,  0, 1, 100, 120, 202, 500, 3'd2, 0, 1, 0};
    vt[5]  = '{1,   8'd0,  0, 1, 100, 120, 202, 500, 3'd2, 0, 1, 0};
    vt[6]  = '{1,   8'd0,  0, 1, 100, 120, 202, 500, 3'd2, 0, 0, 0};
    vt[7]  = '{1,   8'd19, 0, 0, 100, 120, 202, 500, 3'd1, 1, 0, 0};
    vt[8]  = '{8,   8'd0,  0, 0, 100, 120, 202, 500, 3'd1, 0, OMNI, 0};
    vt[9]  = '{640, 8'd0,  0, 0, 100, 120, 202, 500, 3'd1, 0, 0, 0};
    vt[10] = '{1,   8'd19, 0, 0, 5,   300, 202, 0,   3'd0, 1, 0, 0};
    vt[11] = '{1,   8'd0,  0, 0, 5,   300, 202, 0,   3'd0, 1, 0, 1};
    vt[12] = '{650, 8'd0,  0, 0, 5,   300, 202, 0,   3'd0, 0, 0, 0};
    vt[13] = '{1,   8'd19, 0, 0, 5,   300, 202, 630, 3'd0, 0, 0, 0};
    vt[14] = '{1,   8'd0,  0, 0, 5,   300, 202, 630, 3'd0, 0, 0, 0};
    vt[15] = '{5,   8'd0,  1, 0, 5,   300, 202, 630, 3'd5, 0, 0, 0};
    vt[16] = '{1,   8'd0,  1, 0, 5,   300, 202, 630, 3'd5, 0, 0, 0};
    vt[17] = '{1,   8'd19, 1, 0, 5,   300, 202, 630, 3'd4, 1, 0, 0};
    vt[18] = '{8,   8'd0,  0, 0, 5,   300, 202, 630, 3'd4, 0, 0, 0};

    Reset        = 1'b1;
    keycode      = 8'd0;
    ChefX        = 10'd100;
    ChefY        = 10'd200;
    chef_dir     = 1'b0;
    EnemyX       = 10'd500;
    EnemyY       = 10'd200;
    Enemy1X      = 10'd500;
    Enemy1Y      = 10'd200;
    bonus_pickup = 1'b0;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    chk("reset_state",
        {pepper_count, have_pepper, spraying,
         spray_dir, sausage_hit, egg_hit},
        {3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 19; i++) begin
      keycode      = vt[i].key;
      bonus_pickup = vt[i].bonus;
      chef_dir     = vt[i].dir;
      ChefX        = 10'(vt[i].cx);
      EnemyX       = 10'(vt[i].ex);
      EnemyY       = 10'(vt[i].ey);
      Enemy1X      = 10'(vt[i].e1x);
      repeat (vt[i].ncyc) step();
      chk($sformatf("vec%0d", i),
          {3'd0, pepper_count, spraying,
           sausage_hit, egg_hit},
          {3'd0, vt[i].cnt, vt[i].spr,
           vt[i].sh, vt[i].eh});
    end
    bonus_pickup = 1'b0;

    reset_dut();
    keycode = 8'd19;
    repeat (100) step();
    chk("hold_once", {5'd0, pepper_count}, 8'd2);
    keycode = 8'd0;
    step();
    keycode = 8'd19;
    step();
    chk("press_idle", {4'd0, pepper_count, spraying},
        {4'd0, 3'd1, 1'b1});
    keycode = 8'd0;
    repeat (15) step();
    keycode = 8'd19;
    step();
    chk("press_cooldown", {4'd0, pepper_count, spraying},
        {4'd0, 3'd1, 1'b0});
    keycode = 8'd0;
    repeat (40) step();
    keycode = 8'd19;
    step();
    chk("press_after_cd", {4'd0, pepper_count, spraying},
        {4'd0, 3'd0, 1'b1});
    keycode = 8'd0;

    reset_dut();
    keycode = 8'd19;
    step();
    keycode = 8'd0;
    repeat (3) step();
    Reset = 1'b1;
    #1;
    chk("async_reset", {4'd0, pepper_count, spraying},
        {4'd0, 3'd3, 1'b0});
    model_reset();
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    check_all("reset_release");

    for (int i = 0; i < 4000; i++) begin
      int cx, cy;
      cx = ($urandom % 4 == 0) ? int'($urandom_range(0, 30))
                               : int'($urandom_range(0, 639));
      cy = int'($urandom_range(0, 479));
      keycode      = ($urandom % 3 == 0) ? 8'd19
                                         : 8'($urandom % 4);
      bonus_pickup = ($urandom % 25 == 0);
      chef_dir     = 1'($urandom);
      ChefX        = 10'(cx);
      ChefY        = 10'(cy);
      EnemyX  = clampv(cx + int'($urandom_range(0, 70)) - 35, 1023);
      EnemyY  = clampv(cy + int'($urandom_range(0, 14)) - 7, 1023);
      Enemy1X = clampv(cx + int'($urandom_range(0, 70)) - 35, 1023);
      Enemy1Y = clampv(cy + int'($urandom_range(0, 14)) - 7, 1023);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
